// File: rtl/dot_product_pkg.sv
// ============================================================================
//  Module      : dot_product_pkg
//  Description : Shared constants, FSM state type and result-reduction helper
//                for the dot_product block.
//  Contents    : DP_* default width constants, dp_state_e (IDLE/DONE),
//                dp_saturate() unsigned clamp helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dot_product_pkg;

  localparam int DP_DATA_WIDTH           = 32;
  localparam int DP_VECTOR_WIDTH         = 4;
  localparam int DP_VECTOR_ELEMENT_WIDTH = 8;
  localparam int DP_ADDR_WIDTH           = 5;
  localparam int DP_RESULT_WIDTH         = 2 * DP_VECTOR_ELEMENT_WIDTH;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DONE = 1'b1
  } dp_state_e;

  // Clamp an unsigned sum to the largest value representable in rw bits.
  // Widths of 64 or more pass the sum through untouched.
  function automatic logic [63:0] dp_saturate(input logic [63:0] sum,
                                              input int unsigned rw);
    logic [63:0] max_v;
    if (rw >= 64) begin
      return sum;
    end
    max_v = (64'd1 << rw) - 64'd1;
    return (sum > max_v) ? max_v : sum;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dot_product_lane.sv
// ============================================================================
//  Module      : dot_product_lane
//  Description : One unsigned element multiplier of the dot-product datapath.
//  Ports       : a_i    [ELEM_WIDTH-1:0]    element of vector A
//                b_i    [ELEM_WIDTH-1:0]    element of vector B
//                prod_o [2*ELEM_WIDTH-1:0]  full-width unsigned product
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dot_product_lane #(
  parameter int ELEM_WIDTH = 8
) (
  input  logic [ELEM_WIDTH-1:0]   a_i,
  input  logic [ELEM_WIDTH-1:0]   b_i,
  output logic [2*ELEM_WIDTH-1:0] prod_o
);

  // Operands are widened first so the product keeps every bit.
  assign prod_o = (2*ELEM_WIDTH)'(a_i) * (2*ELEM_WIDTH)'(b_i);

endmodule

`default_nettype wire

// File: rtl/dot_product.sv
// ============================================================================
//  Module      : dot_product
//  Description : Registered unsigned dot product of two packed vectors with a
//                one-edge latency, a one-cycle completion pulse and a
//                wrapping completed-operation counter.
//  Ports       : clk                 clock, rising edge
//                rst                 synchronous active-high reset
//                mem1_input          packed vector A
//                mem2_input          packed vector B
//                start_processing    request, sampled every rising edge
//                dot_product_result  registered result
//                processing_done     one-cycle completion pulse
//                op_count            completed operations, wraps
//  Config      : DOT_PRODUCT_SATURATE_EN - when defined, sums above the
//                result range clamp to all-ones; otherwise they truncate.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dot_product
  import dot_product_pkg::*;
#(
  parameter int DATA_WIDTH           = DP_DATA_WIDTH,
  parameter int VECTOR_WIDTH         = DP_VECTOR_WIDTH,
  parameter int VECTOR_ELEMENT_WIDTH = DP_VECTOR_ELEMENT_WIDTH,
  parameter int ADDR_WIDTH           = DP_ADDR_WIDTH,
  parameter int RESULT_WIDTH         = 2 * VECTOR_ELEMENT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   mem1_input,
  input  logic [DATA_WIDTH-1:0]   mem2_input,
  input  logic                    start_processing,
  output logic [RESULT_WIDTH-1:0] dot_product_result,
  output logic                    processing_done,
  output logic [ADDR_WIDTH-1:0]   op_count
);

  localparam int PROD_W = 2 * VECTOR_ELEMENT_WIDTH;
  // Enough headroom that the full sum of all products never overflows.
  localparam int SUM_W  = PROD_W + $clog2(VECTOR_WIDTH);
  // Leaf count of the adder tree, rounded up to a power of two.
  localparam int NLEAF  = 1 << $clog2(VECTOR_WIDTH);

  // --------------------------------------------------------------------------
  // Datapath: per-element products feeding a binary adder tree.
  // Node 0 is the root; node n has children 2n+1 and 2n+2; leaves start at
  // index NLEAF-1. Unused leaves (non power-of-two widths) are tied to zero.
  // --------------------------------------------------------------------------
  logic [SUM_W-1:0]        w_tree [2*NLEAF-1];
  logic [SUM_W-1:0]        w_sum;
  logic [RESULT_WIDTH-1:0] w_result;

  for (genvar k = 0; k < NLEAF; k++) begin : g_leaf
    if (k < VECTOR_WIDTH) begin : g_lane
      logic [PROD_W-1:0] w_prod;

      dot_product_lane #(
        .ELEM_WIDTH (VECTOR_ELEMENT_WIDTH)
      ) u_lane (
        .a_i    (mem1_input[k*VECTOR_ELEMENT_WIDTH +: VECTOR_ELEMENT_WIDTH]),
        .b_i    (mem2_input[k*VECTOR_ELEMENT_WIDTH +: VECTOR_ELEMENT_WIDTH]),
        .prod_o (w_prod)
      );

      assign w_tree[NLEAF-1+k] = SUM_W'(w_prod);
    end else begin : g_pad
      assign w_tree[NLEAF-1+k] = '0;
    end
  end

  for (genvar n = 0; n < NLEAF-1; n++) begin : g_node
    assign w_tree[n] = w_tree[2*n+1] + w_tree[2*n+2];
  end

  assign w_sum = w_tree[0];

`ifdef DOT_PRODUCT_SATURATE_EN
  assign w_result = RESULT_WIDTH'(dp_saturate(64'(w_sum), RESULT_WIDTH));
`else
  assign w_result = RESULT_WIDTH'(64'(w_sum));
`endif

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  dp_state_e               state_q, state_d;
  logic                    done_q, done_d;
  logic [RESULT_WIDTH-1:0] result_q, result_d;
  logic [ADDR_WIDTH-1:0]   count_q, count_d;

  // State and output registers; reset wins over a coincident start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      result_q <= result_d;
      count_q  <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start_processing ? S_DONE : S_IDLE;
      S_DONE:  state_d = start_processing ? S_DONE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: done is asserted for every cycle spent in DONE, and each
  // accepted start loads a fresh result and advances the counter.
  always_comb begin
    done_d   = (state_d == S_DONE);
    result_d = result_q;
    count_d  = count_q;
    if (start_processing) begin
      result_d = w_result;
      count_d  = count_q + ADDR_WIDTH'(1);
    end
  end

  assign dot_product_result = result_q;
  assign processing_done    = done_q;
  assign op_count           = count_q;

endmodule

`default_nettype wire

// File: tb/tb_dot_product.sv
// ============================================================================
//  Module      : tb_dot_product
//  Description : Self-checking bench for dot_product using directed and
//                randomized operands against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dot_product;

  localparam int DW = 32;
  localparam int EW = 8;
  localparam int VW = 4;
  localparam int AW = 5;
  localparam int RW = 16;

  logic          clk;
  logic          rst;
  logic [DW-1:0] mem1_input;
  logic [DW-1:0] mem2_input;
  logic          start_processing;
  logic [RW-1:0] dot_product_result;
  logic          processing_done;
  logic [AW-1:0] op_count;

  int checks;
  int failures;

  // Reference state
  logic [RW-1:0] exp_res;
  logic          exp_done;
  int            exp_cnt;

  dot_product #(
    .DATA_WIDTH           (DW),
    .VECTOR_WIDTH         (VW),
    .VECTOR_ELEMENT_WIDTH (EW),
    .ADDR_WIDTH           (AW),
    .RESULT_WIDTH         (RW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .mem1_input         (mem1_input),
    .mem2_input         (mem2_input),
    .start_processing   (start_processing),
    .dot_product_result (dot_product_result),
    .processing_done    (processing_done),
    .op_count           (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mathematical dot product, then reduction to the result range.
  function automatic logic [RW-1:0] ref_dot(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    longint unsigned s;
    s = 0;
    for (int k = 0; k < VW; k++) begin
      s += longint'(a[k*EW +: EW]) * longint'(b[k*EW +: EW]);
    end
`ifdef DOT_PRODUCT_SATURATE_EN
    if (s > 65535) s = 65535;
`else
    s = s % 65536;
`endif
    return RW'(s);
  endfunction

  // Apply one cycle of inputs, let the edge happen, advance the model.
  task automatic tick(input logic r, input logic s,
                      input logic [DW-1:0] a, input logic [DW-1:0] b);
    rst              = r;
    start_processing = s;
    mem1_input       = a;
    mem2_input       = b;
    @(posedge clk);
    #1;
    if (r) begin
      exp_res  = '0;
      exp_done = 1'b0;
      exp_cnt  = 0;
    end else if (s) begin
      exp_res  = ref_dot(a, b);
      exp_done = 1'b1;
      exp_cnt  = (exp_cnt + 1) % 32;
    end else begin
      exp_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, $urandom, $urandom);
    tick(1'b1, 1'b0, $urandom, $urandom);
    checks++;
    if (dot_product_result !== 16'd0 || processing_done !== 1'b0 || op_count !== 5'd0) begin
      failures++;
      $display("FAIL reset_state: got res=%0d done=%0b cnt=%0d, want 0/0/0",
               dot_product_result, processing_done, op_count);
    end
  endtask

  task automatic test_basic();
    tick(1'b0, 1'b1, 32'h01020304, 32'h01020304);
    checks++;
    if (dot_product_result !== 16'd30 || processing_done !== 1'b1 || op_count !== 5'd1) begin
      failures++;
      $display("FAIL basic_first: got res=%0d done=%0b cnt=%0d, want 30/1/1",
               dot_product_result, processing_done, op_count);
    end
    // Operands wiggle without a start: result holds, done drops.
    tick(1'b0, 1'b0, $urandom, $urandom);
    checks++;
    if (dot_product_result !== 16'd30 || processing_done !== 1'b0 || op_count !== 5'd1) begin
      failures++;
      $display("FAIL basic_hold: got res=%0d done=%0b cnt=%0d, want 30/0/1",
               dot_product_result, processing_done, op_count);
    end
  endtask

  task automatic test_sequence();
    int table_v [10] = '{30, 54, 86, 126, 174, 230, 294, 366, 446, 534};
    logic [DW-1:0] v;
    for (int i = 0; i < 10; i++) begin
      v = 32'h01020304 + 32'(i) * 32'h01010101;
      tick(1'b0, 1'b1, v, v);
      checks++;
      if (dot_product_result !== 16'(table_v[i]) || processing_done !== 1'b1) begin
        failures++;
        $display("FAIL seq_result[%0d]: got res=%0d done=%0b, want %0d/1",
                 i, dot_product_result, processing_done, table_v[i]);
      end
      for (int j = 0; j < 2; j++) begin
        tick(1'b0, 1'b0, $urandom, $urandom);
        checks++;
        if (dot_product_result !== 16'(table_v[i]) || processing_done !== 1'b0) begin
          failures++;
          $display("FAIL seq_idle[%0d]: got res=%0d done=%0b, want %0d/0",
                   i, dot_product_result, processing_done, table_v[i]);
        end
      end
    end
  endtask

  task automatic test_saturate();
    logic [RW-1:0] want;
`ifdef DOT_PRODUCT_SATURATE_EN
    want = 16'd65535;
`else
    want = 16'd63492;
`endif
    tick(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checks++;
    if (dot_product_result !== want || processing_done !== 1'b1) begin
      failures++;
      $display("FAIL saturate: got res=%0d done=%0b, want %0d/1",
               dot_product_result, processing_done, want);
    end
    tick(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    int base;
    base = int'(op_count);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, $urandom, $urandom);
      checks++;
      if (dot_product_result !== exp_res || processing_done !== 1'b1) begin
        failures++;
        $display("FAIL b2b[%0d]: got res=%0d done=%0b, want %0d/1",
                 i, dot_product_result, processing_done, exp_res);
      end
    end
    checks++;
    if (int'(op_count) !== (base + 3) % 32) begin
      failures++;
      $display("FAIL b2b_count: got %0d, want %0d", op_count, (base + 3) % 32);
    end
    tick(1'b0, 1'b0, $urandom, $urandom);
    checks++;
    if (processing_done !== 1'b0 || dot_product_result !== exp_res) begin
      failures++;
      $display("FAIL b2b_end: got res=%0d done=%0b, want %0d/0",
               dot_product_result, processing_done, exp_res);
    end
  endtask

  task automatic test_reset_priority();
    tick(1'b0, 1'b1, 32'h05050505, 32'h05050505);
    tick(1'b1, 1'b1, 32'h07070707, 32'h07070707);
    checks++;
    if (dot_product_result !== 16'd0 || processing_done !== 1'b0 || op_count !== 5'd0) begin
      failures++;
      $display("FAIL reset_priority: got res=%0d done=%0b cnt=%0d, want 0/0/0",
               dot_product_result, processing_done, op_count);
    end
    // First edge out of reset must accept a start.
    tick(1'b0, 1'b1, 32'h01010101, 32'h02020202);
    checks++;
    if (dot_product_result !== 16'd8 || processing_done !== 1'b1 || op_count !== 5'd1) begin
      failures++;
      $display("FAIL first_after_reset: got res=%0d done=%0b cnt=%0d, want 8/1/1",
               dot_product_result, processing_done, op_count);
    end
  endtask

  task automatic test_wrap();
    tick(1'b1, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 31; i++) tick(1'b0, 1'b1, $urandom, $urandom);
    checks++;
    if (op_count !== 5'd31) begin
      failures++;
      $display("FAIL wrap_31: got %0d, want 31", op_count);
    end
    tick(1'b0, 1'b1, $urandom, $urandom);
    checks++;
    if (op_count !== 5'd0 || dot_product_result !== exp_res) begin
      failures++;
      $display("FAIL wrap_0: got cnt=%0d res=%0d, want 0/%0d",
               op_count, dot_product_result, exp_res);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      checks++;
      if (dot_product_result !== exp_res || processing_done !== exp_done ||
          int'(op_count) !== exp_cnt) begin
        failures++;
        $display("FAIL random[%0d]: got res=%0d done=%0b cnt=%0d, want %0d/%0b/%0d",
                 i, dot_product_result, processing_done, op_count,
                 exp_res, exp_done, exp_cnt);
      end
    end
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    exp_res          = '0;
    exp_done         = 1'b0;
    exp_cnt          = 0;
    rst              = 1'b1;
    start_processing = 1'b0;
    mem1_input       = '0;
    mem2_input       = '0;

    test_reset();
    test_basic();
    test_sequence();
    test_saturate();
    test_back_to_back();
    test_reset_priority();
    test_wrap();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
